// File: rtl/threshold_compress_stream_if.sv
// Valid/ready bundle for the threshold compressor: beat input side and
// packed-word output side. The DUT uses the slave modport.
interface threshold_compress_stream_if #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int N_CH         = 4,
  parameter int ACC_WIDTH    = 16
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [N_CH*ACC_WIDTH-1:0]   in_data_i;
  logic [N_CH*ACC_WIDTH-1:0]   thr_lo_i;
  logic [N_CH*ACC_WIDTH-1:0]   thr_hi_i;
  logic                        flush_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [OUTPUT_WIDTH-1:0]     out_data_o;
  logic                        out_last_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    output thr_lo_i,
    output thr_hi_i,
    output flush_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  thr_lo_i,
    input  thr_hi_i,
    input  flush_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_last_o
  );
endinterface

// File: rtl/threshold_compress_stream.sv
// Streaming ternariser: N_CH accumulators per beat -> trits packed 5/byte.
// Optional trit statistics with THRESHOLD_COMPRESS_STREAM_STATS_EN.
module threshold_compress_stream #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int N_CH         = 4,
  parameter int ACC_WIDTH    = 16
) (
  input logic clk_i,
  input logic rst_i,
  threshold_compress_stream_if.slave bus
`ifdef THRESHOLD_COMPRESS_STREAM_STATS_EN
  ,
  input  logic        stats_clr_i,
  output logic [31:0] cnt_neg_o,
  output logic [31:0] cnt_zero_o,
  output logic [31:0] cnt_pos_o
`endif
);

  localparam int NBYTES = OUTPUT_WIDTH / 8;
  localparam int T      = 5 * NBYTES;
  localparam int BEATS  = T / N_CH;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic [1:0]              dig [T];
  logic [1:0]              cur_dig [T];
  logic [1:0]              new_dig [N_CH];
  logic                    flush_pending;
  logic                    out_valid;
  logic [OUTPUT_WIDTH-1:0] out_data;
  logic                    out_last;
  logic [OUTPUT_WIDTH-1:0] word;

  logic last_beat;
  logic in_rdy;
  logic hs;
  logic full;
  logic flush_req;
  logic flush_live;
  logic out_free;
  logic do_flush;
  logic load;

  // Digit encoding is trit+1: 0 -> -1, 1 -> 0, 2 -> +1
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [ACC_WIDTH-1:0] x;
    logic signed [ACC_WIDTH-1:0] lo;
    logic signed [ACC_WIDTH-1:0] hi;
    assign x  = bus.in_data_i[c*ACC_WIDTH +: ACC_WIDTH];
    assign lo = bus.thr_lo_i[c*ACC_WIDTH +: ACC_WIDTH];
    assign hi = bus.thr_hi_i[c*ACC_WIDTH +: ACC_WIDTH];
    assign new_dig[c] = (x < lo) ? 2'd0 :
                        (x < hi) ? 2'd1 : 2'd2;
  end

  assign last_beat = (cnt == CW'(BEATS - 1));
  assign in_rdy    = !flush_pending &&
                     !(last_beat && out_valid && !bus.out_ready_i);
  assign hs        = bus.in_valid_i && in_rdy;
  assign full      = hs && last_beat;

  always_comb begin
    cnt_nxt = cnt;
    if (full)
      cnt_nxt = '0;
    else if (hs)
      cnt_nxt = cnt + CW'(1);
  end

  // A beat arriving with a flush is absorbed first; a completed word
  // leaves nothing for the flush to do.
  assign flush_req  = bus.flush_i || flush_pending;
  assign flush_live = flush_req && !full && (cnt_nxt != '0);
  assign out_free   = !out_valid || bus.out_ready_i;
  assign do_flush   = flush_live && out_free;
  assign load       = full || do_flush;

  // Word view: stored beats, the beat being accepted, then zero-trit pad
  always_comb begin
    for (int i = 0; i < T; i++) begin
      cur_dig[i] = 2'd1;
      if (hs && (i / N_CH) == int'(cnt))
        cur_dig[i] = new_dig[i % N_CH];
      else if ((i / N_CH) < int'(cnt))
        cur_dig[i] = dig[i];
    end
  end

  always_comb begin
    word = '0;
    for (int j = 0; j < NBYTES; j++) begin
      word[8*j +: 8] = 8'(cur_dig[5*j])
                     + 8'(cur_dig[5*j+1]) * 8'd3
                     + 8'(cur_dig[5*j+2]) * 8'd9
                     + 8'(cur_dig[5*j+3]) * 8'd27
                     + 8'(cur_dig[5*j+4]) * 8'd81;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt           <= '0;
      flush_pending <= 1'b0;
      for (int i = 0; i < T; i++)
        dig[i] <= 2'd0;
    end else begin
      cnt           <= do_flush ? '0 : cnt_nxt;
      flush_pending <= flush_live && !out_free;
      for (int i = 0; i < T; i++) begin
        if (hs && (i / N_CH) == int'(cnt))
          dig[i] <= new_dig[i % N_CH];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_last  <= do_flush;
    end else if (bus.out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.out_last_o  = out_last;

`ifdef THRESHOLD_COMPRESS_STREAM_STATS_EN
  logic [31:0] add_neg;
  logic [31:0] add_zero;
  logic [31:0] add_pos;
  logic [31:0] st_neg;
  logic [31:0] st_zero;
  logic [31:0] st_pos;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    add_neg  = '0;
    add_zero = '0;
    add_pos  = '0;
    for (int c = 0; c < N_CH; c++) begin
      unique case (new_dig[c])
        2'd0:    add_neg  = add_neg + 32'd1;
        2'd1:    add_zero = add_zero + 32'd1;
        default: add_pos  = add_pos + 32'd1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_neg  <= '0;
      st_zero <= '0;
      st_pos  <= '0;
    end else if (stats_clr_i) begin
      st_neg  <= '0;
      st_zero <= '0;
      st_pos  <= '0;
    end else if (hs) begin
      st_neg  <= sat_add(st_neg, add_neg);
      st_zero <= sat_add(st_zero, add_zero);
      st_pos  <= sat_add(st_pos, add_pos);
    end
  end

  assign cnt_neg_o  = st_neg;
  assign cnt_zero_o = st_zero;
  assign cnt_pos_o  = st_pos;
`endif

endmodule

// File: doc/threshold_compress_stream.md
Name: threshold_compress_stream

Overview:
- Streaming, parametrised successor to the single-lane threshold compressor.
- Accepts N_CH signed accumulator values per beat over a valid/ready handshake and ternarises each one against its own low/high threshold pair.
- Packs the resulting trits 5-per-byte into OUTPUT_WIDTH-bit words and emits them on a backpressured output stream.
- Supports flushing a partially filled word. Sits between the MAC datapath and the activation write-back path.

Parameters:
- OUTPUT_WIDTH, 32: output word width in bits; must be a multiple of 8.
- N_CH, 4: activations per input beat; T = 5*OUTPUT_WIDTH/8 must be divisible by N_CH.
- ACC_WIDTH, 16: signed width of each accumulator and each threshold.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- in_data_i  in  N_CH*ACC_WIDTH  signed accumulators; channel c occupies bits [c*ACC_WIDTH +: ACC_WIDTH].
- thr_lo_i  in  N_CH*ACC_WIDTH  per-channel signed low thresholds.
- thr_hi_i  in  N_CH*ACC_WIDTH  per-channel signed high thresholds.
- flush_i  in  1  single-cycle request to emit the partially filled word.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts the word.
- out_data_o  out  OUTPUT_WIDTH  packed trit word.
- out_last_o  out  1  word was produced by a flush (may be padded).

Behaviour:
- Reset (rst_i=1, async): beat counter=0, pack register=0, out_valid_o=0, out_data_o=0, out_last_o=0, flush-pending=0.
- Reset mid-word discards the partial word and any pending flush; nothing is emitted.
- Ternarisation, signed compare per channel, sampled at handshake: x<lo gives -1; else x<hi gives 0; else +1. If lo>hi, the -1 rule has priority.
- Packing:
  - Channel c of beat b (b = 0..BEATS-1, BEATS = T/N_CH) writes trit index b*N_CH+c.
  - Byte j = sum over k=0..4 of (t[5j+k]+1)*3^k, giving values 0..242.
  - Bytes are little-endian in out_data_o, byte j at [8j +: 8].
- Word completion:
  - The handshake on beat BEATS-1 loads the packed word into the output register.
  - out_valid_o rises the next cycle (latency 1). The beat counter wraps to 0.
  - out_last_o=0 for words completed this way.
- Output register holds data stable while out_valid_o && !out_ready_i.
- On out_valid_o && out_ready_i with no new load that cycle: out_valid_o goes to 0.
- On out_valid_o && out_ready_i with a simultaneous load: the register reloads and out_valid_o stays 1 (back-to-back words, no bubble).
- in_ready_o = !flush_pending && !(cnt==BEATS-1 && out_valid_o && !out_ready_i).
  - Completed words always have a free output slot.
  - Combinational path out_ready_i to in_ready_o is permitted.
- Flush handling:
  - If an input handshake occurs in the same cycle as flush_i, the beat is absorbed first, then the flush applies.
  - If that beat completed the word, the flush becomes a no-op.
  - With cnt>0 after absorption: remaining trits are padded with 0 (digit 1). The word loads with out_last_o=1 and cnt returns to 0.
  - With cnt==0 (nothing buffered): flush is ignored; no word is emitted.
  - If the output register is occupied and not draining, the flush is latched in flush_pending. in_ready_o=0 until the padded word loads.
- out_data_o and out_last_o are don't-care-stable but must equal their last loaded value while out_valid_o=0.

Optional Feature:
- Macro: THRESHOLD_COMPRESS_STREAM_STATS_EN.
- When defined, three additional outputs are present:
  - cnt_neg_o, cnt_zero_o, cnt_pos_o, each 32 bits.
  - Saturating counts of -1/0/+1 trits over all accepted beats; padding trits are not counted.
  - Cleared by rst_i. Also cleared by a stats_clr_i input (1 bit), which takes priority over an increment in the same cycle.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Full byte: OUTPUT_WIDTH=8, N_CH=1, lo=-10, hi=10; beats -20,0,20,10,-10 (trits -1,0,1,1,0) -> one cycle after 5th handshake, out_valid_o=1, out_data_o=156, out_last_o=0.
- Flush of partial word: same config; beats -20,20 then flush_i -> out_data_o=123 (digits 0,2,1,1,1), out_last_o=1; next flush with cnt==0 emits nothing.
- Default params with out_ready_i=0: feed 10 beats -> first word held stable; in_ready_o=0 on 10th beat until out_ready_i=1. Then back-to-back words with no bubble, contents matching the golden model.
- Simultaneous beat+flush on the 3rd of 5 beats -> padded word contains 3 beats' trits, out_last_o=1. Flush while output is blocked -> flush_pending, in_ready_o=0, word emitted after drain.
- Threshold corners: x==lo -> 0, x==hi -> +1, lo>hi with x<lo -> -1; signed extremes -32768 and 32767 with ACC_WIDTH=16.
- rst_i asserted after 3 beats and while out_valid_o=1 -> all outputs 0 immediately. A subsequent 5-beat sequence produces a clean word with no residue.
